// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Types and helpers shared by the UART receiver and transmitter.
//   - uart_rx_state_t : receiver frame-tracking states
//   - MIN_CPB         : smallest usable clocks-per-bit ratio
//   - cycles_per_bit  : integer clocks per serial bit (truncating divide)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Below this ratio there is no room for a distinct mid-bit sample point.
  localparam int MIN_CPB = 4;

  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//   Consumer-side bundle of the UART receiver.
//   rx_data   : received byte, meaningful while rx_valid is high
//   rx_valid  : a byte is held and not yet acknowledged
//   rx_ack    : consumer pops the held byte
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped
//   master = receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ack
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample their inputs at the
  // same edge; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. Synchronizes the serial line, finds the start edge,
//   samples each bit at its centre, and holds one received byte until the
//   consumer acknowledges it.
//   CLK_HZ / BAUD : system clock and line rate; CPB = CLK_HZ / BAUD
//   clk           : system clock, rising edge
//   reset         : synchronous, active-high; aborts any frame in progress
//   rx            : asynchronous serial input, idles high
//   bus           : consumer bundle (rx_data, rx_valid, rx_ack,
//                   frame_err, overrun)
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  uart_rx_if.master   bus
);

  localparam int CPB   = cycles_per_bit(CLK_HZ, BAUD);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  // Counter values at which the sample is taken. The counter is cleared on
  // the edge that enters a state, so HALF cycles later it reads HALF-1.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  if (CPB < MIN_CPB) begin : g_bad_cpb
    $error("uart_rx: CLK_HZ / BAUD must be at least %0d", MIN_CPB);
  end

  logic           rxs;
  logic           rxs_q;
  uart_rx_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           brk;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      brk           <= 1'b0;
      rxs_q         <= 1'b1;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      rxs_q         <= rxs;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;

      // NOTE: a later non-blocking assignment to the same flop in this block
      // wins, so a delivery in the STOP branch overrides this ack-clear.
      if (bus.rx_valid && bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (brk) begin
            // After a framing error the line may sit low (break); wait for
            // it to return high before looking for the next start edge.
            if (rxs) begin
              brk <= 1'b0;
            end
          end else if (rxs_q && !rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // Line already back high at mid start bit: a glitch, not a frame.
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // Returning at mid stop bit leaves half a bit to catch the next
            // start edge of a back-to-back frame.
            state <= IDLE;
            if (rxs) begin
              if (!bus.rx_valid || bus.rx_ack) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
            end else begin
              bus.frame_err <= 1'b1;
              brk           <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx: reset values, a table of frames with
//   hand-derived results, a randomized run against a held-byte model, and
//   directed sequences for latency, glitch, break, overrun and reset abort.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD   = 115_200;
  localparam int CPB    = CLK_HZ / BAUD;          // 104
  localparam int HALF   = CPB / 2;                // 52
  // Drive cycle of the start bit -> first cycle rx_valid reads high:
  // 2 sync cycles to the detected edge t0, then t0+HALF+9*CPB+1.
  localparam int LAT    = 2 + HALF + 9 * CPB + 1; // 991

  logic clk = 1'b0;
  logic reset;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int   fe_cnt     = 0;
  int   ov_cnt     = 0;
  int   rise_cyc   = -1;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
    if (bus.rx_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = bus.rx_valid;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // All main-thread activity stays aligned to 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, then the stop bit; leaves the line
  // at the stop level. k is the cycle in which the start bit was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int k);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  task automatic ack_pulse(input string name);
    bus.rx_ack = 1'b1;
    tick(1);
    bus.rx_ack = 1'b0;
    check(name, 32'(bus.rx_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ack;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs [6];

  int   k, k2, kk, fe0, ov0;
  logic held;
  logic [7:0] last_data;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    rx         = 1'b1;
    bus.rx_ack = 1'b0;
    tick(3);
    check("reset rx_data",   32'(bus.rx_data),   32'd0);
    check("reset rx_valid",  32'(bus.rx_valid),  32'd0);
    check("reset frame_err", 32'(bus.frame_err), 32'd0);
    check("reset overrun",   32'(bus.overrun),   32'd0);
    reset = 1'b0;
    tick(4);

    // ---------------- table-driven frames ----------------
    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 1}; // dropped: FF still held
    vecs[3] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hFF, 1, 0}; // bad stop, FF still held
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0, 0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h81, 1, 0}; // nothing held, data kept
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit, k);
      rx = 1'b1;
      tick(8);
      check($sformatf("vec%0d rx_valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d rx_data", i),  32'(bus.rx_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d overrun", i),   32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
      if (vecs[i].ack) ack_pulse($sformatf("vec%0d ack", i));
    end

    // ---------------- randomized frames vs held-byte model ----------------
    held      = 1'b0;
    last_data = 8'h81;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       stop_ok;
      logic       do_ack;
      int         exp_fe, exp_ov;
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 4) != 0);
      do_ack  = 1'($urandom_range(0, 1));
      exp_fe  = 0;
      exp_ov  = 0;
      if (!stop_ok)   exp_fe = 1;
      else if (held)  exp_ov = 1;
      else begin
        held      = 1'b1;
        last_data = b;
      end
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(b, stop_ok, k);
      rx = 1'b1;
      tick($urandom_range(1, CPB));
      check($sformatf("rnd%0d rx_valid", i),  32'(bus.rx_valid), 32'(held));
      check($sformatf("rnd%0d rx_data", i),   32'(bus.rx_data),  32'(last_data));
      check($sformatf("rnd%0d frame_err", i), 32'(fe_cnt - fe0), 32'(exp_fe));
      check($sformatf("rnd%0d overrun", i),   32'(ov_cnt - ov0), 32'(exp_ov));
      if (do_ack) begin
        ack_pulse($sformatf("rnd%0d ack", i));
        held = 1'b0;
      end
    end
    if (held) ack_pulse("rnd final ack");
    tick(CPB);

    // ---------------- 0xA5 latency and ack ----------------
    send_frame(8'hA5, 1'b1, k);
    check("a5 rise cycle", 32'(rise_cyc), 32'(k + LAT));
    check("a5 rx_data",    32'(bus.rx_data), 32'hA5);
    ack_pulse("a5 ack");

    // ---------------- back-to-back 0x00, 0xFF ----------------
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, k);
    fork
      send_frame(8'hFF, 1'b1, k2);
      begin
        check("b2b first data",  32'(bus.rx_data),  32'h00);
        check("b2b first valid", 32'(bus.rx_valid), 32'd1);
        ack_pulse("b2b first ack");
      end
    join
    check("b2b second rise", 32'(rise_cyc), 32'(k2 + LAT));
    check("b2b second data", 32'(bus.rx_data), 32'hFF);
    ack_pulse("b2b second ack");
    check("b2b errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // ---------------- start-bit glitch ----------------
    fe0 = fe_cnt;
    rx  = 1'b0;
    tick(20);
    rx  = 1'b1;
    tick(3 * CPB);
    check("glitch rx_valid",  32'(bus.rx_valid), 32'd0);
    check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h3C, 1'b1, k);
    check("after glitch data",  32'(bus.rx_data),  32'h3C);
    check("after glitch valid", 32'(bus.rx_valid), 32'd1);
    ack_pulse("after glitch ack");

    // ---------------- framing error with break ----------------
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, k);
    tick(2 * CPB);
    rx = 1'b1;
    tick(CPB);
    check("break frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("break rx_valid",  32'(bus.rx_valid), 32'd0);
    send_frame(8'h3C, 1'b1, k);
    check("after break data",  32'(bus.rx_data),  32'h3C);
    check("after break valid", 32'(bus.rx_valid), 32'd1);
    check("after break fe",    32'(fe_cnt - fe0), 32'd1);
    ack_pulse("after break ack");

    // ---------------- overrun without ack ----------------
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, k);
    send_frame(8'h22, 1'b1, k);
    check("overrun count", 32'(ov_cnt - ov0), 32'd1);
    check("overrun data",  32'(bus.rx_data),  32'h11);
    check("overrun valid", 32'(bus.rx_valid), 32'd1);
    ack_pulse("overrun ack");

    // ---------------- ack in the delivery cycle ----------------
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, k);
    kk = cyc;
    fork
      send_frame(8'h22, 1'b1, k2);
      begin
        tick(LAT - 1);             // cycle of the stop sample
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
      end
    join
    check("ack-deliver overrun", 32'(ov_cnt - ov0), 32'd0);
    check("ack-deliver data",    32'(bus.rx_data),  32'h22);
    check("ack-deliver valid",   32'(bus.rx_valid), 32'd1);
    ack_pulse("ack-deliver ack");

    // ---------------- reset mid-frame ----------------
    send_frame(8'h5A, 1'b1, k);    // left held so the reset must clear it
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    begin
      logic [7:0] b;
      b  = 8'h99;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
        rx = b[i];
        tick(CPB);
      end
      rx = b[4];
      tick(HALF);
      reset = 1'b1;
      rx    = 1'b1;
      tick(1);
      reset = 1'b0;
    end
    tick(3 * CPB);
    check("reset-abort rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset-abort rx_data",  32'(bus.rx_data),  32'd0);
    check("reset-abort errors",   32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send_frame(8'h42, 1'b1, k);
    check("after reset rise", 32'(rise_cyc), 32'(k + LAT));
    check("after reset data", 32'(bus.rx_data), 32'h42);
    ack_pulse("after reset ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receiving end of the 8N1 serial link that `uart_tx` drives. It samples the asynchronous `rx` line in the `clk` domain, reassembles one byte per frame, and holds it in a single-entry output register until the consumer acknowledges it. It sits beside the CPU's peripheral bus and runs from the same 12 MHz system clock. It flags framing errors and overruns to the consumer.

## Interface

- `CLK_HZ`, default 12_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  received byte; valid while `rx_valid` is high.
- `rx_valid`  out  1  level; high while a byte is held and not yet acknowledged.
- `rx_ack`  in  1  consumer pops the held byte; ignored when `rx_valid` is low.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation

- `CPB = CLK_HZ / BAUD`, truncated integer division (104 at the defaults). `HALF = CPB / 2` (52). Elaboration fails if `CPB < 4`.
- Bit counter is 3 bits. The cycle counter is `$clog2(CPB)` bits, counts 0..CPB-1 and reloads on each sample.
- `rx` passes through a 2-FF synchronizer whose flops reset to 1. `rxs` is the synchronized value. `rxs_q` is `rxs` delayed one cycle.
- The FSM has four states: IDLE, START, DATA and STOP.
- IDLE: a falling edge (`rxs_q`=1, `rxs`=0) moves to START and clears the counter.
- IDLE with `brk` set: the FSM first waits for `rxs`=1, clears `brk`, and then arms edge detection.
- START: after HALF cycles, sample `rxs`. If it is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no output.
- DATA: every CPB cycles, shift `rxs` into the shift register, LSB first. After the 8th bit, go to STOP.
- STOP: after CPB cycles, sample `rxs`.
  - If it is 1, deliver the byte and go to IDLE.
  - If it is 0, pulse `frame_err`, discard the byte, set `brk` and go to IDLE.
- Delivery when `rx_valid`=0 or `rx_ack`=1 that cycle: load `rx_data` and set `rx_valid`=1. There is no overrun.
- Delivery when `rx_valid`=1 and `rx_ack`=0: drop the new byte, keep `rx_data` and pulse `overrun`.
- `rx_ack` with `rx_valid`=1 and no delivery in the same cycle: `rx_valid` goes to 0 on the next edge and `rx_data` holds its value.

## Timing

- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0. State is IDLE, `brk`=0 and the synchronizer flops are 1.
- Synchronizer latency is 2 cycles from a pin change to `rxs`.
- Let t0 be the cycle in which the edge is detected. Samples occur at these cycles:
  - Start bit: t0+HALF.
  - Data bit i: t0+HALF+(i+1)·CPB.
  - Stop bit: t0+HALF+9·CPB.
- `rx_valid`, `frame_err` and `overrun` update on the edge after the stop sample.
- The FSM is back in IDLE half a bit before the stop bit ends, so back-to-back frames are received without loss.
- Reset asserted mid-frame aborts the frame: no delivery and no error pulse. Any byte already held is cleared.

## Structure

- Package `uart_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t`.
  - The helper function `cycles_per_bit(clk_hz, baud)`.
  - These are shared with `uart_tx`.
- Sub-module `sync_2ff` is a two-flop synchronizer with a reset-value parameter. It is instantiated with value 1 for `rx`.
- The FSM, counters, shift register and output register live in `uart_rx`.

## Test plan

- 0xA5 driven at 115200 baud from `uart_tx` → `rx_data`=0xA5, with `rx_valid` rising at t0+52+9·104+1. `rx_ack` pulsed → `rx_valid` is 0 on the next cycle.
- 0x00 then 0xFF sent back-to-back with an ack after each → both received in order with no error pulses.
- `rx` low for 20 cycles, then high → no `rx_valid` and no `frame_err`. A following 0x3C is received correctly.
- Frame 0x55 with the stop bit forced low, line held low for 2 bit times, then 0x3C → one `frame_err` pulse, no delivery from the bad frame, then `rx_data`=0x3C.
- 0x11 then 0x22 with no ack → one `overrun` pulse and `rx_data` stays 0x11.
  - Repeat with `rx_ack` asserted in the delivery cycle of 0x22 → no overrun and `rx_data`=0x22.
- `reset` asserted for 1 cycle during data bit 4 of 0x99 → no delivery and no error pulses. The next frame, 0x42, is received correctly.
